// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the 2-read/1-write register file.
package regfile_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_DEPTH    = 16;
    localparam bit DEF_ZERO_REG = 1'b1;

    // Address width for a given depth; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef logic [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/regfile_2r1w_mux_n1.sv
// Combinational N:1 word selector; selects beyond N-1 yield zero.
module mux_n1
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_DEPTH,
    parameter int SEL_W = addr_w(N)
) (
    input  logic [WIDTH-1:0] data [N],
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] out
);

    // Compare-and-select avoids indexing past N when N is not a power of two.
    always_comb begin
        out = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                out = data[i];
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with two registered read ports, one write port,
// write-to-read bypass and an optional hardwired-zero register 0.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit ZERO_REG = DEF_ZERO_REG,
    localparam int ADDR_W  = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic              rd_valid
);

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;

    assign wr_ok = we && ({1'b0, waddr} < DEPTH_X) && !(ZERO_REG && (waddr == '0));

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  mux_out;
        logic [WIDTH-1:0]  val;

        assign addr = (p == 0) ? ra1 : ra2;

        mux_n1 #(
            .WIDTH (WIDTH),
            .N     (DEPTH),
            .SEL_W (ADDR_W)
        ) u_mux (
            .data (mem),
            .sel  (addr),
            .out  (mux_out)
        );

        // wr_ok already excludes out-of-range and zero-register writes.
        always_comb begin
            val = mux_out;
            if (wr_ok && (waddr == addr)) begin
                val = wdata;
            end
            if (ZERO_REG && (addr == '0)) begin
                val = '0;
            end
        end
    end

    // Read handshake: rd_req sampled at edge N makes rd_valid=1 and rd1/rd2
    // carry that request's data after edge N; with rd_req=0 the data holds
    // and rd_valid drops. There is no back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd1      <= '0;
            rd2      <= '0;
            rd_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && (waddr == ADDR_W'(i))) begin
                    mem[i] <= wdata;
                end
            end
            rd_valid <= rd_req;
            if (rd_req) begin
                rd1 <= g_port[0].val;
                rd2 <= g_port[1].val;
            end
        end
    end

endmodule
